core_state_saver: RTL and testbench

Writes a paused core's architectural state into a RAM frame, producing the memory image the core's resume-from-memory path later reads back. Sits upstream of `Core` resume. The scheduler pulses `start` when it deschedules a process; the block captures the core registers, arbitrates for the shared data-RAM port, writes the frame one word per cycle and signals `done`.

---
 rtl/core_state_saver_pkg.sv | 28 ++
 rtl/core_state_saver_frame_word_select.sv | 37 +++
 rtl/core_state_saver.sv | 170 +++++++++++++++++
 tb/tb_core_state_saver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/core_state_saver_pkg.sv
// Shared widths, frame layout offsets, RAM mode encodings and FSM states for the core state saver.
package core_state_saver_pkg;

  localparam int unsigned ADDRESS_BITS = 16;
  localparam int unsigned DATA_BITS    = 16;
  localparam int unsigned IDX_BITS     = 3;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  localparam int unsigned FRAME_PC    = 0;
  localparam int unsigned FRAME_SP    = 1;
  localparam int unsigned FRAME_CSP   = 2;
  localparam int unsigned FRAME_FLAGS = 3;
  localparam int unsigned FRAME_TOS   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } saverState_t;

  // Frame length is the fixed header plus one word per live cached stack entry.
  function automatic logic [IDX_BITS-1:0] frameLength(input logic [1:0] tosValid);
    return IDX_BITS'(FRAME_TOS) + IDX_BITS'(tosValid[0]) + IDX_BITS'(tosValid[1]);
  endfunction

endpackage

// File: rtl/core_state_saver_frame_word_select.sv
// Combinational map from frame word index to RAM offset, data word and last-word flag.
module frame_word_select
  import core_state_saver_pkg::*;
#(
  parameter int unsigned addrBits = ADDRESS_BITS,
  parameter int unsigned dataBits = DATA_BITS,
  parameter int unsigned pcBits   = 9
) (
  input  logic [IDX_BITS-1:0] index,
  input  logic [pcBits-1:0]   programCounter,
  input  logic [addrBits-1:0] stackPointer,
  input  logic [addrBits-1:0] callStackPointer,
  input  logic [dataBits-1:0] topOfStack1,
  input  logic [dataBits-1:0] topOfStack2,
  input  logic [1:0]          tosValid,
  output logic [addrBits-1:0] offset,
  output logic [dataBits-1:0] data,
  output logic                isLast
);

  always_comb begin
    data   = '0;
    offset = addrBits'(index);
    isLast = (index == (frameLength(tosValid) - IDX_BITS'(1)));
    case (index)
      IDX_BITS'(FRAME_PC):    data = dataBits'(programCounter);
      IDX_BITS'(FRAME_SP):    data = dataBits'(stackPointer);
      IDX_BITS'(FRAME_CSP):   data = dataBits'(callStackPointer);
      IDX_BITS'(FRAME_FLAGS): data = dataBits'(tosValid);
      // TOS words pack contiguously, so a lone TOS2 takes the first TOS slot.
      IDX_BITS'(FRAME_TOS):   data = tosValid[0] ? topOfStack1 : topOfStack2;
      IDX_BITS'(FRAME_TOS+1): data = topOfStack2;
      default:                data = '0;
    endcase
  end

endmodule

// File: rtl/core_state_saver.sv
// Captures a paused core's registers and writes them as a RAM frame, one word per granted cycle.
module core_state_saver
  import core_state_saver_pkg::*;
#(
  parameter int unsigned addrBits = ADDRESS_BITS,
  parameter int unsigned dataBits = DATA_BITS,
  parameter int unsigned pcBits   = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addrBits-1:0] frameBase,
  input  logic [pcBits-1:0]   programCounter,
  input  logic [addrBits-1:0] stackPointer,
  input  logic [addrBits-1:0] callStackPointer,
  input  logic [dataBits-1:0] topOfStack1,
  input  logic [dataBits-1:0] topOfStack2,
  input  logic [1:0]          tosValid,
  input  logic                busGrant,
  output logic                busRequest,
  output logic [addrBits-1:0] ramAddress,
  output logic [dataBits-1:0] ramDataIn,
  output logic                ramReadWriteMode,
  output logic                busy,
  output logic                done,
  output logic [IDX_BITS-1:0] frameWords
);

  saverState_t state, stateNext;
  logic [IDX_BITS-1:0] wordIndex, wordIndexNext, selIndex;
  logic [IDX_BITS-1:0] frameWordsNext;
  logic                capture, loadWord, busyNext, busRequestNext, doneNext;
  logic                curIsLast;

  logic [addrBits-1:0] baseSh, spSh, cspSh;
  logic [pcBits-1:0]   pcSh;
  logic [dataBits-1:0] tos1Sh, tos2Sh;
  logic [1:0]          tosValidSh;

  logic [addrBits-1:0] selBase, selSp, selCsp, selOffset;
  logic [pcBits-1:0]   selPc;
  logic [dataBits-1:0] selTos1, selTos2, selData;
  logic [1:0]          selTosValid;
  logic                selLast;

  // Word 0 is prepared from the live inputs on the start edge; later words come from the shadows.
  always_comb begin
    selBase     = baseSh;
    selPc       = pcSh;
    selSp       = spSh;
    selCsp      = cspSh;
    selTos1     = tos1Sh;
    selTos2     = tos2Sh;
    selTosValid = tosValidSh;
    if (state == IDLE) begin
      selBase     = frameBase;
      selPc       = programCounter;
      selSp       = stackPointer;
      selCsp      = callStackPointer;
      selTos1     = topOfStack1;
      selTos2     = topOfStack2;
      selTosValid = tosValid;
    end
  end

  frame_word_select #(
    .addrBits(addrBits),
    .dataBits(dataBits),
    .pcBits  (pcBits)
  ) wordSelect (
    .index           (selIndex),
    .programCounter  (selPc),
    .stackPointer    (selSp),
    .callStackPointer(selCsp),
    .topOfStack1     (selTos1),
    .topOfStack2     (selTos2),
    .tosValid        (selTosValid),
    .offset          (selOffset),
    .data            (selData),
    .isLast          (selLast)
  );

  assign ramReadWriteMode = ((state == WRITE) && busGrant) ? RAM_WRITE : RAM_READ;

  always_comb begin
    stateNext      = state;
    wordIndexNext  = wordIndex;
    selIndex       = wordIndex + IDX_BITS'(1);
    capture        = 1'b0;
    loadWord       = 1'b0;
    busyNext       = busy;
    busRequestNext = busRequest;
    doneNext       = 1'b0;
    frameWordsNext = frameWords;
    case (state)
      IDLE: begin
        selIndex = '0;
        if (start) begin
          capture        = 1'b1;
          loadWord       = 1'b1;
          wordIndexNext  = '0;
          busyNext       = 1'b1;
          busRequestNext = 1'b1;
          stateNext      = WRITE;
        end
      end
      WRITE: begin
        if (busGrant) begin
          if (curIsLast) begin
            stateNext      = DONE;
            busRequestNext = 1'b0;
            doneNext       = 1'b1;
            frameWordsNext = wordIndex + IDX_BITS'(1);
          end else begin
            wordIndexNext = wordIndex + IDX_BITS'(1);
            loadWord      = 1'b1;
          end
        end
      end
      DONE: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wordIndex  <= '0;
      busy       <= 1'b0;
      busRequest <= 1'b0;
      done       <= 1'b0;
      frameWords <= '0;
      ramAddress <= '0;
      ramDataIn  <= '0;
      curIsLast  <= 1'b0;
      baseSh     <= '0;
      pcSh       <= '0;
      spSh       <= '0;
      cspSh      <= '0;
      tos1Sh     <= '0;
      tos2Sh     <= '0;
      tosValidSh <= '0;
    end else begin
      state      <= stateNext;
      wordIndex  <= wordIndexNext;
      busy       <= busyNext;
      busRequest <= busRequestNext;
      done       <= doneNext;
      frameWords <= frameWordsNext;
      if (capture) begin
        baseSh     <= frameBase;
        pcSh       <= programCounter;
        spSh       <= stackPointer;
        cspSh      <= callStackPointer;
        tos1Sh     <= topOfStack1;
        tos2Sh     <= topOfStack2;
        tosValidSh <= tosValid;
      end
      if (loadWord) begin
        ramAddress <= addrBits'(selBase + selOffset);
        ramDataIn  <= selData;
        curIsLast  <= selLast;
      end
    end
  end

endmodule

// File: tb/tb_core_state_saver.sv
// Directed bench for core_state_saver: expected frame words queued at start, checked as writes appear.
module tb_core_state_saver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] frameBase = '0;
  logic [8:0]  programCounter = '0;
  logic [15:0] stackPointer = '0;
  logic [15:0] callStackPointer = '0;
  logic [15:0] topOfStack1 = '0;
  logic [15:0] topOfStack2 = '0;
  logic [1:0]  tosValid = '0;
  logic        busGrant = 1'b1;
  logic        busRequest;
  logic [15:0] ramAddress;
  logic [15:0] ramDataIn;
  logic        ramReadWriteMode;
  logic        busy;
  logic        done;
  logic [2:0]  frameWords;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } ramWord_t;

  ramWord_t expQ[$];
  int tests = 0;
  int fails = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  core_state_saver #(.addrBits(16), .dataBits(16), .pcBits(9)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .frameBase       (frameBase),
    .programCounter  (programCounter),
    .stackPointer    (stackPointer),
    .callStackPointer(callStackPointer),
    .topOfStack1     (topOfStack1),
    .topOfStack2     (topOfStack2),
    .tosValid        (tosValid),
    .busGrant        (busGrant),
    .busRequest      (busRequest),
    .ramAddress      (ramAddress),
    .ramDataIn       (ramDataIn),
    .ramReadWriteMode(ramReadWriteMode),
    .busy            (busy),
    .done            (done),
    .frameWords      (frameWords)
  );

  // Every RAM write must match the next queued frame word.
  always @(negedge clk) begin
    ramWord_t e;
    if (reset === 1'b1 && ramReadWriteMode === 1'b1) begin
      tests++;
      assert (expQ.size() != 0) else begin
        fails++;
        $error("FAIL unexpectedWrite addr=%h data=%h", ramAddress, ramDataIn);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        tests++;
        assert (ramAddress === e.addr && ramDataIn === e.data) else begin
          fails++;
          $error("FAIL ramWrite observed=%h:%h expected=%h:%h", ramAddress, ramDataIn, e.addr, e.data);
        end
      end
    end
    if (reset === 1'b1 && busy === 1'b1 && busGrant === 1'b0) begin
      tests++;
      assert (ramReadWriteMode === 1'b0) else begin
        fails++;
        $error("FAIL writeWithoutGrant observed=%b expected=0", ramReadWriteMode);
      end
    end
    if (done === 1'b1) doneCount++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushFrame(input logic [15:0] base, input logic [8:0] pc, input logic [15:0] sp,
                           input logic [15:0] csp, input logic [15:0] t1, input logic [15:0] t2,
                           input logic [1:0] tv);
    logic [15:0] a;
    a = base;
    expQ.push_back('{a, {7'd0, pc}});  a = a + 16'd1;
    expQ.push_back('{a, sp});          a = a + 16'd1;
    expQ.push_back('{a, csp});         a = a + 16'd1;
    expQ.push_back('{a, {14'd0, tv}}); a = a + 16'd1;
    if (tv[0]) begin expQ.push_back('{a, t1}); a = a + 16'd1; end
    if (tv[1]) expQ.push_back('{a, t2});
  endtask

  checkResetOutputs: assert property (@(posedge clk) 1'b1);

  task automatic checkResetState(input string tag);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_done"}, 16'(done), 16'd0);
    check({tag, "_busRequest"}, 16'(busRequest), 16'd0);
    check({tag, "_mode"}, 16'(ramReadWriteMode), 16'd0);
    check({tag, "_ramAddress"}, ramAddress, 16'd0);
    check({tag, "_ramDataIn"}, ramDataIn, 16'd0);
    check({tag, "_frameWords"}, 16'(frameWords), 16'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 with the block idle again.
  task automatic runSave(input string tag, input logic [15:0] base, input logic [8:0] pc,
                         input logic [15:0] sp, input logic [15:0] csp, input logic [15:0] t1,
                         input logic [15:0] t2, input logic [1:0] tv, input int stallLen,
                         input bit glitch, input int abortCyc);
    int expWords;
    int doneBefore;
    int doneCyc;
    expWords   = 4 + int'(tv[0]) + int'(tv[1]);
    doneBefore = doneCount;
    doneCyc    = 0;
    frameBase = base; programCounter = pc; stackPointer = sp; callStackPointer = csp;
    topOfStack1 = t1; topOfStack2 = t2; tosValid = tv; busGrant = 1'b1; start = 1'b1;
    pushFrame(base, pc, sp, csp, t1, t2, tv);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busyAtStart"}, 16'(busy), 16'd1);
    check({tag, "_busReqAtStart"}, 16'(busRequest), 16'd1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      busGrant = (cyc >= 3 && cyc < 3 + stallLen) ? 1'b0 : 1'b1;
      if (glitch && cyc == 3) begin
        start = 1'b1;
        frameBase = 16'h7777; programCounter = 9'h1AA; stackPointer = 16'hDEAD;
        callStackPointer = 16'hBEEF; topOfStack1 = 16'h5555; topOfStack2 = 16'hAAAA; tosValid = 2'b00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == abortCyc) begin
        #2 reset = 1'b0;
        #1 checkResetState({tag, "_asyncReset"});
        expQ.delete();
        busGrant = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check({tag, "_noDoneAfterAbort"}, 16'(doneCount), 16'(doneBefore));
        return;
      end
      if (done === 1'b1) begin
        doneCyc = cyc;
        check({tag, "_frameWords"}, 16'(frameWords), 16'(expWords));
        check({tag, "_busReqInDone"}, 16'(busRequest), 16'd0);
        check({tag, "_busyInDone"}, 16'(busy), 16'd1);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    busGrant = 1'b1;
    check({tag, "_doneLatency"}, 16'(doneCyc), 16'(expWords + 1 + stallLen));
    @(posedge clk); #1;
    check({tag, "_busyAfterDone"}, 16'(busy), 16'd0);
    check({tag, "_donePulse"}, 16'(done), 16'd0);
    @(posedge clk); #1;
    check({tag, "_allWordsWritten"}, 16'(expQ.size()), 16'd0);
    check({tag, "_oneDone"}, 16'(doneCount), 16'(doneBefore + 1));
    expQ.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkResetState("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    runSave("allValid", 16'h0100, 9'd1, 16'h00FD, 16'd4, 16'd7, 16'd42, 2'b11, 0, 1'b0, 0);
    runSave("tos2Only", 16'h0100, 9'd1, 16'h00FD, 16'd4, 16'd7, 16'd42, 2'b10, 0, 1'b0, 0);
    runSave("tos1Only", 16'h0200, 9'h1FF, 16'h1234, 16'h4321, 16'hCAFE, 16'hF00D, 2'b01, 0, 1'b0, 0);
    runSave("stall", 16'h0100, 9'd1, 16'h00FD, 16'd4, 16'd7, 16'd42, 2'b11, 3, 1'b0, 0);
    runSave("wrap", 16'hFFFE, 9'd3, 16'h0011, 16'h0022, 16'd9, 16'd8, 2'b00, 0, 1'b0, 0);
    runSave("restart", 16'h0100, 9'd1, 16'h00FD, 16'd4, 16'd7, 16'd42, 2'b11, 0, 1'b1, 0);
    runSave("abort", 16'h0300, 9'd5, 16'h00AA, 16'h00BB, 16'd1, 16'd2, 2'b11, 0, 1'b0, 3);
    runSave("afterAbort", 16'h0300, 9'd5, 16'h00AA, 16'h00BB, 16'd1, 16'd2, 2'b11, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
